// File: rtl/otbn_pq_pkg.sv
// Shared definitions for the PQ NTT/INTT helper blocks.
//   BitrevMinLogN / BitrevMaxLogN : accepted range of the transform size exponent
//   BitrevAddrW                   : width of the latched base address
//   bitrev_seq_cfg_t              : run configuration latched at start
//   bitrev_seq_state_e            : sequencer states
package otbn_pq_pkg;

  localparam int unsigned BitrevMinLogN = 6;
  localparam int unsigned BitrevMaxLogN = 12;
  localparam int unsigned BitrevAddrW   = 32;

  typedef struct packed {
    logic [3:0]             log_n;
    logic                   swap_only;
    logic [1:0]             shift;
    logic [BitrevAddrW-1:0] base;
  } bitrev_seq_cfg_t;

  typedef enum logic {
    BitrevSeqIdle = 1'b0,
    BitrevSeqRun  = 1'b1
  } bitrev_seq_state_e;

endpackage

// File: rtl/otbn_bitrev_core.sv
// Combinational bit reversal of the low log_n bits of a value.
// Ports:
//   value    : input value; bits at and above log_n are expected to be 0
//   log_n    : number of low bits to reverse (MinLogN..MaxLogN)
//   reversed : value with its low log_n bits reversed; 0 for out-of-range log_n
// Shared between the bit-reversed index sequencer and the ALU bit-reverse path.
module otbn_bitrev_core #(
  parameter int unsigned MinLogN = 6,
  parameter int unsigned MaxLogN = 12
) (
  input  logic [MaxLogN-1:0] value,
  input  logic [3:0]         log_n,
  output logic [MaxLogN-1:0] reversed
);

  // One fixed-width reversal per supported size, selected by log_n.
  always_comb begin
    reversed = '0;
    for (int w = MinLogN; w <= MaxLogN; w++) begin
      if (log_n == 4'(w)) begin
        for (int b = 0; b < w; b++) begin
          reversed[b] = value[w-1-b];
        end
      end
    end
  end

endmodule

// File: rtl/otbn_bitrev_swap_seq.sv
// Sequential bit-reversed index pair generator for the NTT/INTT reorder pass.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   start_i, abort_i        : start a run (Idle only) / cancel a run (Run only)
//   log_n_i, swap_only_i,
//   shift_i, base_i         : run configuration, latched at an accepted start
//   busy_o                  : high while in Run
//   idx_valid_o/idx_ready_i : handshake for the pair on idx_a_o / idx_b_o
//   idx_a_o, idx_b_o        : base + (i << shift), base + (rev(i) << shift)
//   done_o                  : pulse in the cycle the final pair/skip retires
//   err_o                   : pulse the cycle after a rejected start
module otbn_bitrev_swap_seq
  import otbn_pq_pkg::*;
#(
  parameter int unsigned MinLogN  = BitrevMinLogN,
  parameter int unsigned MaxLogN  = BitrevMaxLogN,
  parameter int unsigned AddrW    = BitrevAddrW,
  parameter int unsigned MaxShift = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [3:0]       log_n_i,
  input  logic             swap_only_i,
  input  logic [1:0]       shift_i,
  input  logic [AddrW-1:0] base_i,
  output logic             busy_o,
  output logic             idx_valid_o,
  input  logic             idx_ready_i,
  output logic [AddrW-1:0] idx_a_o,
  output logic [AddrW-1:0] idx_b_o,
  output logic             done_o,
  output logic             err_o
);

  bitrev_seq_state_e    state_q, state_d;
  logic [MaxLogN-1:0]   cnt_q, cnt_d;
  bitrev_seq_cfg_t      cfg_q, cfg_d;
  logic                 err_q, err_d;
  logic                 done;

  logic [MaxLogN-1:0]   cnt_rev;
  logic [MaxLogN-1:0]   last_idx;
  logic                 running;
  logic                 skip;
  logic                 advance;
  logic                 cfg_ok;

  otbn_bitrev_core #(
    .MinLogN (MinLogN),
    .MaxLogN (MaxLogN)
  ) u_bitrev_core (
    .value    (cnt_q),
    .log_n    (cfg_q.log_n),
    .reversed (cnt_rev)
  );

  assign cfg_ok = (32'(log_n_i) >= 32'(MinLogN)) &&
                  (32'(log_n_i) <= 32'(MaxLogN)) &&
                  (32'(shift_i) <= 32'(MaxShift));

  // N-1 as a mask of the low log_n bits.
  assign last_idx = ~({MaxLogN{1'b1}} << cfg_q.log_n);

  assign running = (state_q == BitrevSeqRun);
  // Fixed points and the second half of each swap pair are skipped in swap-only mode.
  assign skip    = cfg_q.swap_only & (cnt_q >= cnt_rev);
  assign advance = running & (skip | idx_ready_i);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    err_d   = 1'b0;
    done    = 1'b0;
    case (state_q)
      BitrevSeqIdle: begin
        if (start_i) begin
          if (cfg_ok) begin
            cfg_d.log_n     = log_n_i;
            cfg_d.swap_only = swap_only_i;
            cfg_d.shift     = shift_i;
            cfg_d.base      = BitrevAddrW'(base_i);
            cnt_d           = '0;
            state_d         = BitrevSeqRun;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BitrevSeqRun: begin
        // Abort wins over a same-cycle handshake; that pair counts as consumed.
        if (abort_i) begin
          state_d = BitrevSeqIdle;
          cnt_d   = '0;
        end else if (advance) begin
          if (cnt_q == last_idx) begin
            state_d = BitrevSeqIdle;
            cnt_d   = '0;
            done    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = BitrevSeqIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BitrevSeqIdle;
      cnt_q   <= '0;
      cfg_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      err_q   <= err_d;
    end
  end

  // Indices come only from registered state, so they hold under backpressure.
  assign idx_a_o = AddrW'(cfg_q.base) + (AddrW'(cnt_q)   << cfg_q.shift);
  assign idx_b_o = AddrW'(cfg_q.base) + (AddrW'(cnt_rev) << cfg_q.shift);

  assign busy_o      = running;
  assign idx_valid_o = running & ~skip;
  // A reset arriving in the final cycle must not leak a completion pulse.
  assign done_o      = done & ~rst_i;
  assign err_o       = err_q;

endmodule

// File: tb/tb_otbn_bitrev_swap_seq.sv
module tb_otbn_bitrev_swap_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [3:0]  log_n;
  logic        swap_only;
  logic [1:0]  shift;
  logic [31:0] base;
  logic        busy;
  logic        valid;
  logic        ready;
  logic [31:0] idx_a;
  logic [31:0] idx_b;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  otbn_bitrev_swap_seq dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .abort_i     (abort),
    .log_n_i     (log_n),
    .swap_only_i (swap_only),
    .shift_i     (shift),
    .base_i      (base),
    .busy_o      (busy),
    .idx_valid_o (valid),
    .idx_ready_i (ready),
    .idx_a_o     (idx_a),
    .idx_b_o     (idx_b),
    .done_o      (done),
    .err_o       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int rev(input int v, input int n);
    int r = 0;
    for (int b = 0; b < n; b++) r |= ((v >> b) & 1) << (n - 1 - b);
    return r;
  endfunction

  // Pulses start for one cycle; returns at the negedge where Run shows i=0.
  task automatic start_run(input logic [3:0] ln, input logic sw, input logic [1:0] sh,
                           input logic [31:0] bs);
    @(negedge clk);
    start = 1'b1; log_n = ln; swap_only = sw; shift = sh; base = bs;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; log_n = 4'd0; swap_only = 1'b0;
    shift = 2'd0; base = 32'd0; ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 1'b0)    begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (idx_a !== 32'd0) begin errors++; $display("FAIL reset_idx_a got %h want 0", idx_a); end
    checks++; if (idx_b !== 32'd0) begin errors++; $display("FAIL reset_idx_b got %h want 0", idx_b); end
  endtask

  task automatic test_full();
    ready = 1'b1;
    start_run(4'd6, 1'b0, 2'd0, 32'd0);
    for (int i = 0; i < 64; i++) begin
      #1;
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL full_valid i=%0d got %b want 1", i, valid); end
      checks++; if (idx_a !== i[31:0]) begin errors++; $display("FAIL full_a i=%0d got %0d want %0d", i, idx_a, i); end
      checks++; if (idx_b !== 32'(rev(i, 6))) begin errors++; $display("FAIL full_b i=%0d got %0d want %0d", i, idx_b, rev(i, 6)); end
      checks++; if (done !== (i == 63)) begin errors++; $display("FAIL full_done i=%0d got %b want %b", i, done, (i == 63)); end
      if (i == 3) begin
        checks++; if (idx_b !== 32'd48) begin errors++; $display("FAIL full_b3 got %0d want 48", idx_b); end
      end
      @(negedge clk);
    end
    #1;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL full_busy_after got %b want 0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL full_valid_after got %b want 0", valid); end
  endtask

  task automatic test_swap_only();
    int nv = 0;
    int ns = 0;
    int dstep = -1;
    int fa[4];
    int fb[4];
    ready = 1'b1;
    start_run(4'd6, 1'b1, 2'd0, 32'd0);
    for (int s = 0; s < 64; s++) begin
      #1;
      if (valid) begin
        if (nv < 4) begin fa[nv] = int'(idx_a); fb[nv] = int'(idx_b); end
        checks++; if (!(idx_a < idx_b)) begin errors++; $display("FAIL swap_order got a=%0d b=%0d want a<b", idx_a, idx_b); end
        nv++;
      end else begin
        ns++;
      end
      if (done) dstep = s;
      @(negedge clk);
    end
    #1;
    checks++; if (nv != 28) begin errors++; $display("FAIL swap_pairs got %0d want 28", nv); end
    checks++; if (ns != 36) begin errors++; $display("FAIL swap_skips got %0d want 36", ns); end
    checks++; if (dstep != 63) begin errors++; $display("FAIL swap_done_step got %0d want 63", dstep); end
    checks++; if (fa[0] != 1 || fb[0] != 32) begin errors++; $display("FAIL swap_p0 got (%0d,%0d) want (1,32)", fa[0], fb[0]); end
    checks++; if (fa[1] != 2 || fb[1] != 16) begin errors++; $display("FAIL swap_p1 got (%0d,%0d) want (2,16)", fa[1], fb[1]); end
    checks++; if (fa[2] != 3 || fb[2] != 48) begin errors++; $display("FAIL swap_p2 got (%0d,%0d) want (3,48)", fa[2], fb[2]); end
    checks++; if (fa[3] != 4 || fb[3] != 8) begin errors++; $display("FAIL swap_p3 got (%0d,%0d) want (4,8)", fa[3], fb[3]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL swap_busy_after got %b want 0", busy); end
  endtask

  task automatic test_shift_base();
    ready = 1'b1;
    start_run(4'd12, 1'b0, 2'd2, 32'h0000_1000);
    for (int s = 0; s < 4096; s++) begin
      #1;
      if (s == 1) begin
        checks++; if (idx_a !== 32'h1004) begin errors++; $display("FAIL sb_a1 got %h want 00001004", idx_a); end
        checks++; if (idx_b !== 32'h3000) begin errors++; $display("FAIL sb_b1 got %h want 00003000", idx_b); end
      end
      if (s == 4095) begin
        checks++; if (idx_a !== 32'h4FFC) begin errors++; $display("FAIL sb_a4095 got %h want 00004ffc", idx_a); end
        checks++; if (idx_b !== 32'h4FFC) begin errors++; $display("FAIL sb_b4095 got %h want 00004ffc", idx_b); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL sb_done got %b want 1", done); end
      end
      @(negedge clk);
    end
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sb_busy_after got %b want 0", busy); end
    // Wrap-around of base + index.
    start_run(4'd6, 1'b0, 2'd0, 32'hFFFF_FFF0);
    repeat (32) @(negedge clk);
    #1;
    checks++; if (idx_a !== 32'h0000_0010) begin errors++; $display("FAIL wrap_a got %h want 00000010", idx_a); end
    checks++; if (idx_b !== 32'hFFFF_FFF1) begin errors++; $display("FAIL wrap_b got %h want fffffff1", idx_b); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_abort_busy got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    ready = 1'b1;
    start_run(4'd6, 1'b0, 2'd0, 32'd0);
    repeat (2) @(negedge clk);
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (valid !== 1'b1 || idx_a !== 32'd2 || idx_b !== 32'd16) begin
        errors++; $display("FAIL bp_hold k=%0d got v=%b (%0d,%0d) want v=1 (2,16)", k, valid, idx_a, idx_b);
      end
      // Changed inputs and a start request mid-run must be ignored.
      start = (k == 1); log_n = 4'd7; shift = 2'd3; base = 32'h100;
      @(negedge clk);
    end
    start = 1'b0;
    ready = 1'b1;
    #1;
    checks++; if (idx_a !== 32'd2 || idx_b !== 32'd16) begin errors++; $display("FAIL bp_hs got (%0d,%0d) want (2,16)", idx_a, idx_b); end
    @(negedge clk);
    #1;
    checks++; if (idx_a !== 32'd3 || idx_b !== 32'd48) begin errors++; $display("FAIL bp_next got (%0d,%0d) want (3,48)", idx_a, idx_b); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_error_start();
    logic [3:0] bad [2];
    bad[0] = 4'd5; bad[1] = 4'd13;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      log_n = bad[j]; shift = 2'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_pulse log_n=%0d got %b want 1", bad[j], err); end
      checks++; if (busy !== 1'b0 || valid !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL err_idle log_n=%0d got busy=%b valid=%b done=%b want 0", bad[j], busy, valid, done);
      end
      @(negedge clk);
      #1;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_width log_n=%0d got %b want 0", bad[j], err); end
    end
  endtask

  task automatic test_abort_reset();
    ready = 1'b1;
    start_run(4'd6, 1'b0, 2'd0, 32'd0);
    repeat (10) @(negedge clk);
    #1;
    checks++; if (idx_a !== 32'd10) begin errors++; $display("FAIL ab_at10 got %0d want 10", idx_a); end
    abort = 1'b1;
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ab_done got %b want 0", done); end
    @(negedge clk);
    abort = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL ab_idle got busy=%b valid=%b done=%b want 0", busy, valid, done);
    end
    start_run(4'd6, 1'b0, 2'd0, 32'd0);
    #1;
    checks++; if (valid !== 1'b1 || idx_a !== 32'd0 || idx_b !== 32'd0) begin
      errors++; $display("FAIL ab_restart got v=%b (%0d,%0d) want v=1 (0,0)", valid, idx_a, idx_b);
    end
    @(negedge clk);
    repeat (19) @(negedge clk);
    #1;
    checks++; if (idx_a !== 32'd20 || idx_b !== 32'd10) begin errors++; $display("FAIL rs_at20 got (%0d,%0d) want (20,10)", idx_a, idx_b); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || valid !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL rs_ctrl got busy=%b valid=%b done=%b err=%b want 0", busy, valid, done, err);
    end
    checks++; if (idx_a !== 32'd0 || idx_b !== 32'd0) begin errors++; $display("FAIL rs_idx got (%h,%h) want (0,0)", idx_a, idx_b); end
  endtask

  initial begin
    test_reset();
    test_full();
    test_swap_only();
    test_shift_base();
    test_backpressure();
    test_error_start();
    test_abort_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/otbn_bitrev_swap_seq.md
Name: otbn_bitrev_swap_seq

Overview:
Sequential bit-reversed index generator for the PQ NTT/INTT reordering pass.
- Once started, steps a counter i over 0..N-1 with N = 2^log_n, log_n in 6..12.
- Emits index pairs (base + (i << shift), base + (rev_log_n(i) << shift)) over a valid/ready handshake to the data-memory access sequencer.
- Optional swap-only mode suppresses fixed points and duplicate pairs, so each in-place swap is issued exactly once.

Parameters:
- MinLogN, 6, smallest accepted log_n.
- MaxLogN, 12, largest accepted log_n; sets counter width.
- AddrW, 32, width of base and emitted indices.
- MaxShift, 3, largest accepted shift_i value.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  start request, sampled in Idle only.
- abort_i  in  1  cancel run; no done_o pulse.
- log_n_i  in  4  transform size exponent.
- swap_only_i  in  1  1: emit only pairs with i < rev(i).
- shift_i  in  2  left shift applied to both indices.
- base_i  in  AddrW  base added to both shifted indices.
- busy_o  out  1  high in Run.
- idx_valid_o  out  1  pair valid.
- idx_ready_i  in  1  consumer accepts pair.
- idx_a_o  out  AddrW  base + (i << shift).
- idx_b_o  out  AddrW  base + (rev(i) << shift).
- done_o  out  1  one-cycle pulse on completion.
- err_o  out  1  one-cycle pulse on rejected start.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state=Idle, counter=0, config registers=0, and all outputs 0.
- Reset mid-run: returns to Idle; no done_o or err_o pulse is generated.
- States: Idle, Run.
- Start accept: in Idle, start_i=1 with MinLogN <= log_n_i <= MaxLogN and shift_i <= MaxShift:
  - latch log_n, swap_only, shift and base;
  - clear the counter;
  - go to Run next cycle.
- Start reject: a start request with an out-of-range log_n or shift pulses err_o for 1 cycle and stays in Idle.
- start_i is ignored in Run.
- Config changes on the inputs during Run have no effect; only the latched values are used.
- rev(i): reverses the low log_n bits of i. Bits above log_n are 0, since i < N.
  - Implemented as a mux over per-width reversals, 6..MaxLogN.
- Index arithmetic: each index is base + (x << shift), computed modulo 2^AddrW; carry is discarded.
- Run, emit cycle:
  - skip = swap_only & (i >= rev(i)); idx_valid_o = !skip.
  - idx_a_o and idx_b_o are driven from registered state (counter and latched config) only.
  - While idx_valid_o=1 and idx_ready_i=0, idx_a_o and idx_b_o stay stable and the counter holds.
- Counter advance: on a handshake (valid & ready), or on a skip cycle, which takes exactly 1 cycle with valid low.
- Throughput: 1 pair/cycle when idx_ready_i is held high.
- Completion: when the counter advances from N-1, go to Idle and pulse done_o in that same transition cycle, which is the cycle of the last handshake or skip.
  - busy_o drops the following cycle.
- Full-mode pair count: N pairs, including fixed points such as (0,0) and (N-1,N-1).
- Swap-only pair count: (N - 2^ceil(log_n/2))/2 pairs. Examples: 28 for log_n=6, 56 for 7, 2016 for 12.
- abort_i in Run:
  - go to Idle next cycle and drop idx_valid_o; no done_o;
  - abort takes priority over a same-cycle handshake, which is treated as accepted by the consumer.
- abort_i in Idle is ignored.

Decomposition:
- Shared package otbn_pq_pkg:
  - constants BitrevMinLogN and BitrevMaxLogN;
  - typedef bitrev_seq_cfg_t, a struct of log_n, swap_only, shift and base;
  - enum bitrev_seq_state_e {BitrevSeqIdle, BitrevSeqRun}.
- Sub-module otbn_bitrev_core:
  - purely combinational, parametrised by MinLogN and MaxLogN;
  - inputs value and log_n, output reversed value;
  - reusable by the ALU bit-reverse instruction path.

Test Plan:
- Full mode: log_n=6, swap_only=0, shift=0, base=0, ready=1 → 64 consecutive valid cycles. Pairs (0,0),(1,32),(2,16),(3,48)…(63,63); done_o pulses with the last pair; busy_o low the next cycle.
- Swap-only mode: log_n=6, swap_only=1 → exactly 28 handshakes. First pairs (1,32),(2,16),(3,48),(4,8); every pair has a<b; 36 skip cycles; done_o after 64 counter steps.
- Shift and base: log_n=12, shift=2, base=0x1000 → pair for i=1 is (0x1004,0x3000); for i=4095, (0x4FFC,0x4FFC). Also check base=0xFFFF_FFF0, shift=0, i=32 → a=0x0000_0010 (wrap).
- Backpressure: hold idx_ready_i low for 3 cycles while pair (2,16) is presented → outputs stay stable and the counter holds; the next cycle after ready rises presents (3,48).
- Error start: start with log_n=5, then with log_n=13 → err_o pulses 1 cycle each; busy_o, idx_valid_o and done_o remain 0.
- Abort and reset mid-run:
  - abort_i at i=10 → Idle next cycle, no done_o; a fresh start restarts from i=0.
  - rst_i at i=20 → all outputs 0 the next cycle.
